// File: rtl/temp_sample_ctrl.sv
// temp_sample_ctrl
//   Sequences the on-chip temperature ADC. A free-running timer issues a
//   conversion request every SAMPLE_DIV cycles over a req/ack handshake.
//   2**AVG_LOG2 accepted samples are averaged into one 12-bit reading.
//   The reading drives an over-temperature alarm with hysteresis. A lower
//   code means a hotter die.
//
//   Ports
//     clk        in   1   system clock
//     rst_n      in   1   asynchronous active-low reset
//     enable     in   1   1 = run sampling; 0 = finish current conversion, then idle
//     adc_req    out  1   conversion request, held until ack or timeout
//     adc_ack    in   1   ADC done; adc_data valid this cycle
//     adc_data   in   12  raw ADC temperature code
//     temp_avg   out  12  last averaged reading (12'hFFF after reset)
//     temp_valid out  1   1-cycle pulse when temp_avg updates
//     alarm      out  1   over-temperature flag
//     adc_err    out  1   1-cycle pulse on handshake timeout
//
//   Build option
//     TEMP_ALARM_LATCH_EN : when defined, the alarm is sticky once set and
//                           clears only on rst_n. Default build: hysteresis.
module temp_sample_ctrl #(
  parameter int unsigned SAMPLE_DIV = 50000,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned ALARM_CODE = 3625,
  parameter int unsigned HYST       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        adc_req,
  input  logic        adc_ack,
  input  logic [11:0] adc_data,
  output logic [11:0] temp_avg,
  output logic        temp_valid,
  output logic        alarm,
  output logic        adc_err
);

  localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned AW = 12 + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;

  localparam logic [TW-1:0] LP_TIMER_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [WW-1:0] LP_WAIT_LAST  = WW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LP_CNT_FULL   = CW'(1 << AVG_LOG2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [WW-1:0] r_wait;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [11:0]   r_avg;
  logic          r_valid;
  logic          r_alarm;
  logic          r_err;

  logic          w_tick;
  logic          w_timeout;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_last;
  logic [11:0]   w_avg_new;
  logic          w_alarm_nxt;

  // Sample timer: runs only while enabled, so a re-enable always waits a
  // full period before the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (!enable || (r_timer == LP_TIMER_LAST)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  assign w_tick    = enable && (r_timer == LP_TIMER_LAST);
  assign w_timeout = (r_wait == LP_WAIT_LAST);
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_last    = (w_cnt_nxt == LP_CNT_FULL);
  assign w_avg_new = 12'(r_acc >> AVG_LOG2);

  // Alarm decision on the freshly computed average.
  always_comb begin
    w_alarm_nxt = r_alarm;
    if ({20'd0, w_avg_new} <= ALARM_CODE) begin
      w_alarm_nxt = 1'b1;
    end
`ifdef TEMP_ALARM_LATCH_EN
`else
    else if ({20'd0, w_avg_new} >= (ALARM_CODE + HYST)) begin
      w_alarm_nxt = 1'b0;
    end
`endif
  end

  // temp_avg, temp_valid and alarm load on the ACCUM->DONE edge so all
  // three are presented together during the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_avg   <= '1;
      r_valid <= 1'b0;
      r_alarm <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Ticks seen outside IDLE are simply dropped.
          if (w_tick) begin
            r_wait  <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack on the timeout cycle still counts as a good sample.
          if (adc_ack) begin
            r_acc   <= r_acc + AW'(adc_data);
            r_state <= S_ACCUM;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        S_ACCUM: begin
          r_cnt <= w_cnt_nxt;
          if (w_last) begin
            r_avg   <= w_avg_new;
            r_valid <= 1'b1;
            r_alarm <= w_alarm_nxt;
            r_state <= S_DONE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DONE: begin
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign adc_req    = (r_state == S_REQ);
  assign temp_avg   = r_avg;
  assign temp_valid = r_valid;
  assign alarm      = r_alarm;
  assign adc_err    = r_err;

endmodule

// File: tb/tb_temp_sample_ctrl.sv
module tb_temp_sample_ctrl;

  localparam int unsigned DIV = 8;
  localparam int unsigned L2  = 2;
  localparam int unsigned NS  = 1 << L2;
  localparam int unsigned TO  = 5;
  localparam int unsigned AC  = 3625;
  localparam int unsigned HY  = 16;
`ifdef TEMP_ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        adc_ack = 1'b0;
  logic [11:0] adc_data = '0;
  logic        adc_req;
  logic [11:0] temp_avg;
  logic        temp_valid;
  logic        alarm;
  logic        adc_err;

  temp_sample_ctrl #(
    .SAMPLE_DIV (DIV),
    .AVG_LOG2   (L2),
    .TIMEOUT    (TO),
    .ALARM_CODE (AC),
    .HYST       (HY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .adc_req    (adc_req),
    .adc_ack    (adc_ack),
    .adc_data   (adc_data),
    .temp_avg   (temp_avg),
    .temp_valid (temp_valid),
    .alarm      (alarm),
    .adc_err    (adc_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual %0d required %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model (event/time based) ----------------
  longint      cyc = 0;
  int unsigned streak = 0;       // consecutive enabled cycles
  bit          m_req = 1'b0;
  int unsigned m_age = 0;
  longint      idle_from = 0;    // first cycle the controller can take a tick
  int unsigned samples[$];
  longint      valid_at = -1;
  int unsigned pend_avg = 0;
  logic        e_req = 1'b0, e_valid = 1'b0, e_err = 1'b0, e_alarm = 1'b0;
  logic [11:0] e_avg = 12'hFFF;

  always @(posedge clk) begin : model
    longint c;
    bit tick;
    int unsigned sum;
    c = cyc;
    cyc++;
    if (!rst_n) begin
      streak = 0; m_req = 0; m_age = 0; idle_from = 0; samples.delete();
      valid_at = -1; e_req = 0; e_valid = 0; e_err = 0; e_alarm = 0; e_avg = 12'hFFF;
    end else begin
      tick   = enable && ((streak % DIV) == DIV - 1);
      streak = enable ? streak + 1 : 0;
      e_valid = 0;
      e_err   = 0;
      if (m_req) begin
        if (adc_ack) begin
          samples.push_back(int'(adc_data));
          m_req = 0;
          if (samples.size() == NS) begin
            sum = 0;
            foreach (samples[i]) sum += samples[i];
            pend_avg  = sum / NS;
            valid_at  = c + 2;
            idle_from = c + 3;
            samples.delete();
          end else begin
            idle_from = c + 2;
          end
        end else if (m_age == TO - 1) begin
          m_req = 0;
          e_err = 1;
          samples.delete();
          idle_from = c + 1;
        end else begin
          m_age++;
        end
      end else if (tick && c >= idle_from) begin
        m_req = 1;
        m_age = 0;
      end
      if (c + 1 == valid_at) begin
        e_valid = 1;
        e_avg   = 12'(pend_avg);
        if (pend_avg <= AC) e_alarm = 1;
        else if (!LATCH && pend_avg >= AC + HY) e_alarm = 0;
      end
      e_req = m_req;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    if (!rst_n) begin
      chk("adc_req", 32'(adc_req), 0);
      chk("temp_valid", 32'(temp_valid), 0);
      chk("temp_avg", 32'(temp_avg), 32'hFFF);
      chk("alarm", 32'(alarm), 0);
      chk("adc_err", 32'(adc_err), 0);
    end else begin
      chk("adc_req", 32'(adc_req), 32'(e_req));
      chk("temp_valid", 32'(temp_valid), 32'(e_valid));
      chk("temp_avg", 32'(temp_avg), 32'(e_avg));
      chk("alarm", 32'(alarm), 32'(e_alarm));
      chk("adc_err", 32'(adc_err), 32'(e_err));
    end
  end

  // ---------------- ADC responder ----------------
  logic [11:0] dq[$];
  int          fixed_delay = 3;  // -1 = random 0..6 (5,6 time out)
  bit          spurious_en = 1'b0;
  int          acks_taken = 0;

  function automatic logic [11:0] rand_data();
    if ($urandom_range(0, 1) == 0) return 12'($urandom_range(3590, 3660));
    return 12'($urandom_range(0, 4095));
  endfunction

  initial begin : responder
    bit prev_req;
    int req_k;
    int cur_delay;
    prev_req = 0; req_k = 0; cur_delay = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        adc_ack = 0;
        prev_req = 0;
      end else if (adc_req) begin
        if (!prev_req) begin
          req_k = 0;
          cur_delay = (fixed_delay < 0) ? int'($urandom_range(0, 6)) : fixed_delay;
        end else begin
          req_k++;
        end
        if (req_k == cur_delay) begin
          adc_ack  = 1;
          adc_data = (dq.size() > 0) ? dq.pop_front() : rand_data();
          acks_taken++;
        end else begin
          adc_ack  = 0;
          adc_data = 12'($urandom);
        end
        prev_req = 1;
      end else begin
        adc_ack  = spurious_en && ($urandom_range(0, 7) == 0);
        adc_data = 12'($urandom);
        prev_req = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_valid(input int maxc, input string nm);
    bit got;
    got = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (temp_valid === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: temp_valid actual 0 required 1 within %0d cycles", nm, maxc);
    end
  endtask

  task automatic wait_acks(input int target, input int maxc, input string nm);
    bit got;
    got = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (acks_taken >= target) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: acks actual %0d required %0d", nm, acks_taken, target);
    end
  endtask

  task automatic push4(input int unsigned a, input int unsigned b, input int unsigned c,
                       input int unsigned d);
    dq.push_back(12'(a)); dq.push_back(12'(b)); dq.push_back(12'(c)); dq.push_back(12'(d));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int a0, reqc, got;
    logic errreq;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_adc_req", 32'(adc_req), 0);
    chk("rst_temp_avg", 32'(temp_avg), 32'hFFF);
    chk("rst_alarm", 32'(alarm), 0);
    @(posedge clk); #3; rst_n = 1;
    @(posedge clk); #3; enable = 1;

    // averaging and alarm hysteresis
    push4(4000, 4001, 4002, 4003);
    wait_valid(300, "t1_valid");
    chk("t1_avg", 32'(temp_avg), 4001);
    chk("t1_alarm", 32'(alarm), 0);
    push4(3600, 3600, 3600, 3600);
    wait_valid(300, "t2a_valid");
    chk("t2a_avg", 32'(temp_avg), 3600);
    chk("t2a_alarm", 32'(alarm), 1);
    push4(3630, 3630, 3630, 3630);
    wait_valid(300, "t2b_valid");
    chk("t2b_alarm", 32'(alarm), 1);
    push4(3641, 3641, 3641, 3641);
    wait_valid(300, "t2c_valid");
    chk("t2c_avg", 32'(temp_avg), 3641);
    chk("t2c_alarm", 32'(alarm), LATCH ? 1 : 0);
    push4(4000, 4000, 4000, 4000);
    wait_valid(300, "t6_valid");
    chk("t6_alarm", 32'(alarm), LATCH ? 1 : 0);

    // handshake timeout
    fixed_delay = 99;
    reqc = 0; got = 0; errreq = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (adc_req) reqc++;
      if (adc_err) begin
        got = 1;
        errreq = adc_req;
        break;
      end
    end
    chk("t3_err_seen", 32'(got), 1);
    chk("t3_req_cycles", 32'(reqc), TO);
    chk("t3_req_dropped", 32'(errreq), 0);
    fixed_delay = 3;
    dq.push_back(12'd1000); dq.push_back(12'd1000);
    a0 = acks_taken;
    wait_acks(a0 + 2, 100, "t4_two_acks");

    // reset during an open request
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (adc_req) begin
        got = 1;
        break;
      end
    end
    chk("t4_req_open", 32'(got), 1);
    #1 rst_n = 0;
    #1;
    chk("t4_req_drop", 32'(adc_req), 0);
    chk("t4_avg_rst", 32'(temp_avg), 32'hFFF);
    chk("t4_alarm_rst", 32'(alarm), 0);
    dq.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    push4(2000, 2000, 2000, 2004);
    a0 = acks_taken;
    wait_valid(300, "t4_valid");
    chk("t4_avg", 32'(temp_avg), 2001);
    chk("t4_acks", 32'(acks_taken - a0), 4);

    // enable drop with a partial average pending
    dq.push_back(12'd100); dq.push_back(12'd200);
    a0 = acks_taken;
    wait_acks(a0 + 2, 100, "t5_two_acks");
    @(posedge clk); #3 enable = 0;
    reqc = 0;
    for (int i = 0; i < 3 * int'(DIV); i++) begin
      @(negedge clk);
      if (adc_req) reqc++;
    end
    chk("t5_no_req", 32'(reqc), 0);
    @(posedge clk); #3 enable = 1;
    dq.push_back(12'd300); dq.push_back(12'd400);
    wait_valid(300, "t5_valid");
    chk("t5_avg", 32'(temp_avg), 250);

    // randomized phase
    fixed_delay = -1;
    spurious_en = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #3;
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 0;
        @(posedge clk); #3;
        rst_n = 1;
      end
    end
    spurious_en = 0;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
